// File: rtl/wishbone_response_tracker.sv
// wishbone_response_tracker: counts accepted Wishbone requests, forwards their responses, drains strays after CYC drops
//   Ports: CLK/RST_n (async active-low); I_CYC/I_STB in, I_STALL/I_ACK/I_ERR/I_RTY/I_DAT/I_TGD out (initiator side);
//   T_CYC/T_STB out, T_STALL/T_ACK/T_ERR/T_RTY/T_DAT/T_TGD in (target side).
//   Macro WB_RSPTRACK_BYPASS_EN: defined -> responses forwarded combinationally; undefined -> one-cycle registered.
module wishbone_response_tracker #(
  parameter int DataWidth      = 8,
  parameter int TGDWidth       = 1,
  parameter int MaxOutstanding = 4,
  parameter int FlushTimeout   = 16
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 I_CYC,
  input  logic                 I_STB,
  output logic                 I_STALL,
  output logic                 I_ACK,
  output logic                 I_ERR,
  output logic                 I_RTY,
  output logic [DataWidth-1:0] I_DAT,
  output logic [TGDWidth-1:0]  I_TGD,
  output logic                 T_CYC,
  output logic                 T_STB,
  input  logic                 T_STALL,
  input  logic                 T_ACK,
  input  logic                 T_ERR,
  input  logic                 T_RTY,
  input  logic [DataWidth-1:0] T_DAT,
  input  logic [TGDWidth-1:0]  T_TGD
);
  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
  localparam logic [7:0]  MAX_OUT = 8'(MaxOutstanding);
  localparam logic [15:0] FT      = 16'(FlushTimeout);
  state_t                state_q, state_d;
  logic [7:0]            out_q, out_d, out_n;
  logic [15:0]           timer_q, timer_d, timer_n;
  logic                  ack_d, err_d, rty_d;
  logic [DataWidth-1:0]  dat_q, dat_d;
  logic [TGDWidth-1:0]   tgd_q, tgd_d;
  logic                  accept, rsp, fwd;
  always_comb begin
    // outputs are gated with RST_n so they reach their reset values immediately
    T_CYC   = RST_n & ((state_q == FLUSH) | I_CYC);
    T_STB   = RST_n & (state_q == ACTIVE) & I_CYC & I_STB & (out_q < MAX_OUT);
    I_STALL = ~RST_n | T_STALL | (out_q == MAX_OUT) | (state_q == FLUSH);
    accept  = T_STB & ~T_STALL;
    rsp     = T_CYC & (T_ACK | T_ERR | T_RTY) & (out_q != 8'd0);
    fwd     = (state_q == ACTIVE) & rsp;
    out_n   = (accept & ~rsp) ? out_q + 8'd1 : (rsp & ~accept) ? out_q - 8'd1 : out_q;
    timer_n = (timer_q == 16'd0) ? 16'd0 : timer_q - 16'd1;
    state_d = (state_q == IDLE)   ? (I_CYC ? ACTIVE : IDLE) :
              (state_q == ACTIVE) ? (I_CYC ? ACTIVE : (out_q == 8'd0) ? IDLE : FLUSH) :
              ((out_n == 8'd0) || (timer_n == 16'd0)) ? IDLE : FLUSH;
    timer_d = (state_q == ACTIVE && !I_CYC && out_q != 8'd0) ? FT :
              (state_q == FLUSH) ? timer_n : timer_q;
    // a flush timeout abandons whatever is still outstanding
    out_d   = (state_q == FLUSH && timer_n == 16'd0) ? 8'd0 : out_n;
    err_d   = fwd & T_ERR;
    rty_d   = fwd & ~T_ERR & T_RTY;
    ack_d   = fwd & ~T_ERR & ~T_RTY & T_ACK;
    dat_d   = fwd ? T_DAT : dat_q;
    tgd_d   = fwd ? T_TGD : tgd_q;
  end
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      timer_q <= '0;
      dat_q   <= '0;
      tgd_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      timer_q <= timer_d;
      dat_q   <= dat_d;
      tgd_q   <= tgd_d;
    end
  end
`ifdef WB_RSPTRACK_BYPASS_EN
  always_comb begin
    I_ACK = ack_d;
    I_ERR = err_d;
    I_RTY = rty_d;
    I_DAT = dat_d;
    I_TGD = tgd_d;
  end
`else
  logic ack_q, err_q, rty_q;
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rty_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      rty_q <= rty_d;
    end
  end
  always_comb begin
    I_ACK = ack_q;
    I_ERR = err_q;
    I_RTY = rty_q;
    I_DAT = dat_q;
    I_TGD = tgd_q;
  end
`endif
endmodule

// File: tb/tb_wishbone_response_tracker.sv
// tb_wishbone_response_tracker: vector table, corner sequences and random run against a reference model
module tb_wishbone_response_tracker;
  localparam int MAXO = 4;
  localparam int FT   = 16;
`ifdef WB_RSPTRACK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst_n;
  logic i_cyc, i_stb, t_stall, t_ack, t_err, t_rty;
  logic [7:0] t_dat;
  logic t_tgd;
  logic i_stall, i_ack, i_err, i_rty, t_cyc, t_stb;
  logic [7:0] i_dat;
  logic i_tgd;
  int checks = 0, failures = 0;
  int m_mode, m_out, m_timer;
  bit m_ack, m_err, m_rty;
  logic [7:0] m_dat;
  logic s_tcyc, s_tstb, s_istall, s_ack, s_err, s_rty, s_tgd;
  logic [7:0] s_dat;
  typedef struct {
    bit [5:0]   in;
    logic [7:0] dat;
    bit [5:0]   out;
    logic [7:0] idat;
  } vec_t;
  vec_t tbl[18];
  always #5 clk = ~clk;
  wishbone_response_tracker #(.DataWidth(8), .TGDWidth(1), .MaxOutstanding(MAXO), .FlushTimeout(FT)) dut (
    .CLK(clk), .RST_n(rst_n), .I_CYC(i_cyc), .I_STB(i_stb), .I_STALL(i_stall),
    .I_ACK(i_ack), .I_ERR(i_err), .I_RTY(i_rty), .I_DAT(i_dat), .I_TGD(i_tgd),
    .T_CYC(t_cyc), .T_STB(t_stb), .T_STALL(t_stall), .T_ACK(t_ack), .T_ERR(t_err),
    .T_RTY(t_rty), .T_DAT(t_dat), .T_TGD(t_tgd));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_mode = 0; m_out = 0; m_timer = 0;
    m_ack = 0; m_err = 0; m_rty = 0; m_dat = 8'h00;
  endtask
  // one clock: drive at posedge+1, compare at negedge, advance model at posedge
  task automatic step(input bit cyc, stb, stall, ack, err, rty, input logic [7:0] dat);
    bit e_tcyc, e_tstb, e_istall, rsp, fwd, e_ack, e_err, e_rty;
    logic [7:0] e_dat;
    i_cyc = cyc; i_stb = stb; t_stall = stall; t_ack = ack; t_err = err; t_rty = rty;
    t_dat = dat; t_tgd = dat[0];
    e_tcyc   = (m_mode == 2) || cyc;
    e_tstb   = (m_mode == 1) && cyc && stb && (m_out < MAXO);
    e_istall = stall || (m_out == MAXO) || (m_mode == 2);
    rsp      = e_tcyc && (ack || err || rty) && (m_out > 0);
    fwd      = (m_mode == 1) && rsp;
    e_err = BYP ? fwd && err : m_err;
    e_rty = BYP ? fwd && !err && rty : m_rty;
    e_ack = BYP ? fwd && !err && !rty && ack : m_ack;
    e_dat = (BYP && fwd) ? dat : m_dat;
    @(negedge clk);
    s_tcyc = t_cyc; s_tstb = t_stb; s_istall = i_stall;
    s_ack = i_ack; s_err = i_err; s_rty = i_rty; s_dat = i_dat; s_tgd = i_tgd;
    check("model", {s_tcyc, s_tstb, s_istall, s_ack, s_err, s_rty, s_tgd, s_dat},
          {e_tcyc, e_tstb, e_istall, e_ack, e_err, e_rty, e_dat[0], e_dat});
    @(posedge clk);
    m_out = m_out + int'(e_tstb && !stall) - int'(rsp);
    m_err = fwd && err;
    m_rty = fwd && !err && rty;
    m_ack = fwd && !err && !rty && ack;
    if (fwd) m_dat = dat;
    if (m_mode == 0) begin
      if (cyc) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!cyc) begin
        if (m_out == 0) m_mode = 0;
        else begin m_mode = 2; m_timer = FT; end
      end
    end else begin
      if (m_timer > 0) m_timer--;
      if (m_out == 0 || m_timer == 0) begin m_out = 0; m_mode = 0; end
    end
    #1;
  endtask
  function automatic vec_t v(bit [5:0] in, logic [7:0] dat, bit [5:0] out, logic [7:0] idat);
    vec_t r;
    r.in = in; r.dat = dat; r.out = out; r.idat = idat;
    return r;
  endfunction
  task automatic check_reset_outputs(input string name);
    check(name, {t_cyc, t_stb, i_stall, i_ack, i_err, i_rty, i_tgd, i_dat}, {7'b0010000, 8'h00});
  endtask
  initial begin
    bit rc;
    // in = {cyc,stb,stall,ack,err,rty}; out = {tcyc,tstb,istall,iack,ierr,irty} for registered forwarding
    tbl[0]  = v(6'b000000, 8'h00, 6'b000000, 8'h00);
    tbl[1]  = v(6'b110000, 8'h00, 6'b100000, 8'h00);
    tbl[2]  = v(6'b111000, 8'h00, 6'b111000, 8'h00);
    tbl[3]  = v(6'b110000, 8'h00, 6'b110000, 8'h00);
    tbl[4]  = v(6'b110000, 8'h00, 6'b110000, 8'h00);
    tbl[5]  = v(6'b110000, 8'h00, 6'b110000, 8'h00);
    tbl[6]  = v(6'b110000, 8'h00, 6'b110000, 8'h00);
    tbl[7]  = v(6'b110000, 8'h00, 6'b101000, 8'h00);
    tbl[8]  = v(6'b100100, 8'h11, 6'b101000, 8'h00);
    tbl[9]  = v(6'b100100, 8'h22, 6'b100100, 8'h11);
    tbl[10] = v(6'b110100, 8'hA5, 6'b110100, 8'h22);
    tbl[11] = v(6'b100110, 8'h5A, 6'b100100, 8'hA5);
    tbl[12] = v(6'b100000, 8'h00, 6'b100010, 8'h5A);
    tbl[13] = v(6'b100101, 8'h77, 6'b100000, 8'h5A);
    tbl[14] = v(6'b100100, 8'h99, 6'b100001, 8'h77);
    tbl[15] = v(6'b100000, 8'h00, 6'b100000, 8'h77);
    tbl[16] = v(6'b000000, 8'h00, 6'b000000, 8'h77);
    tbl[17] = v(6'b000000, 8'h00, 6'b000000, 8'h77);
    rst_n = 1'b0;
    i_cyc = 1'b1; i_stb = 1'b1; t_stall = 0; t_ack = 1; t_err = 0; t_rty = 0; t_dat = 8'hFF; t_tgd = 1;
    #2;
    check_reset_outputs("reset_initial");
    @(negedge clk);
    rst_n = 1'b1;
    i_cyc = 0; i_stb = 0; t_ack = 0;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 18; i++) begin
      int j;
      step(tbl[i].in[5], tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0], tbl[i].dat);
      // with combinational forwarding the pulse shows up one row earlier
      j = (BYP && i < 17) ? i + 1 : i;
      check($sformatf("vec%0d", i), {s_tcyc, s_tstb, s_istall, s_ack, s_err, s_rty, s_tgd, s_dat},
            {tbl[i].out[5:3], tbl[j].out[2:0], tbl[j].idat[0], tbl[j].idat});
    end
    step(1, 0, 0, 0, 0, 0, 8'h00);
    step(1, 1, 0, 0, 0, 0, 8'h00);
    step(1, 1, 0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 0, 0, 8'h00);
    for (int k = 0; k < FT; k++) begin
      step(k >= 8, k >= 8, 0, 0, 0, 0, 8'h00);
      check($sformatf("flush_timeout_c%0d", k), {s_tcyc, s_tstb, s_istall, s_ack | s_err | s_rty}, 4'b1010);
    end
    step(1, 1, 0, 0, 0, 0, 8'h00);
    check("idle_after_timeout", {s_tcyc, s_tstb, s_istall}, 3'b100);
    for (int k = 0; k < MAXO; k++) begin
      step(1, 1, 0, 0, 0, 0, 8'h00);
      check($sformatf("refill_c%0d", k), {s_tstb, s_istall}, 2'b10);
    end
    step(1, 1, 0, 0, 0, 0, 8'h00);
    check("full_stall", {s_tstb, s_istall}, 2'b01);
    step(1, 0, 0, 1, 0, 0, 8'h3C);
`ifdef WB_RSPTRACK_BYPASS_EN
    check("bypass_ack", {s_ack, s_dat}, {1'b1, 8'h3C});
`endif
    step(1, 0, 0, 0, 0, 0, 8'h00);
`ifndef WB_RSPTRACK_BYPASS_EN
    check("registered_ack", {s_ack, s_dat}, {1'b1, 8'h3C});
`endif
    step(0, 0, 0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 1, 0, 0, 8'hE1);
    check("drain_c1", {s_tcyc, s_istall, s_ack | s_err | s_rty}, 3'b110);
    step(0, 0, 0, 0, 0, 0, 8'h00);
    check("drain_c2", {s_tcyc, s_istall, s_ack | s_err | s_rty}, 3'b110);
    step(0, 0, 0, 0, 1, 0, 8'hE2);
    check("drain_c3", {s_tcyc, s_istall, s_ack | s_err | s_rty}, 3'b110);
    step(0, 0, 0, 0, 0, 1, 8'hE3);
    check("drain_c4", {s_tcyc, s_istall, s_ack | s_err | s_rty}, 3'b110);
    step(0, 0, 0, 0, 0, 0, 8'h00);
    check("drain_idle", {s_tcyc, s_istall, s_ack | s_err | s_rty, s_dat}, {3'b000, 8'h3C});
    step(1, 0, 0, 0, 0, 0, 8'h00);
    step(1, 1, 0, 0, 0, 0, 8'h00);
    step(1, 1, 0, 0, 0, 0, 8'h00);
    step(1, 0, 0, 1, 0, 0, 8'h42);
    rst_n = 1'b0;
    i_cyc = 1'b1; i_stb = 1'b1; t_ack = 1'b1;
    #1;
    check_reset_outputs("reset_mid_transaction");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    i_cyc = 0; i_stb = 0; t_ack = 0;
    model_reset();
    @(posedge clk);
    #1;
    step(1, 0, 0, 1, 0, 0, 8'h55);
    step(1, 0, 0, 1, 0, 0, 8'h56);
    step(1, 0, 0, 0, 0, 0, 8'h00);
    check("no_stale_response", {s_ack, s_dat}, {1'b0, 8'h00});
    rc = 1'b1;
    for (int n = 0; n < 800; n++) begin
      rc = rc ? ($urandom_range(0, 99) >= 5) : ($urandom_range(0, 99) < 30);
      step(rc, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 8'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wishbone_response_tracker.md
WISHBONE_RESPONSE_TRACKER -- requirements
Module: wishbone_response_tracker

Interface
REQ-001 SHALL have parameter DataWidth, 8, width of response data.
REQ-002 SHALL have parameter TGDWidth, 1, width of response tag.
REQ-003 SHALL have parameter MaxOutstanding, 4, maximum accepted-but-unanswered requests (2..255).
REQ-004 SHALL have parameter FlushTimeout, 16, cycles to wait for stray responses after CYC drops (1..65535).
REQ-005 SHALL use one clock and an asynchronous, active-low reset: CLK  in  1  rising-edge clock; RST_n  in  1  async active-low reset.
REQ-006 SHALL have I_CYC  in  1  initiator cycle.
REQ-007 SHALL have I_STB  in  1  initiator strobe.
REQ-008 SHALL have I_STALL  out  1  stall to initiator.
REQ-009 SHALL have I_ACK, I_ERR, I_RTY  out  1 each  response to initiator.
REQ-010 SHALL have I_DAT  out  DataWidth  and  I_TGD  out  TGDWidth  response data and tag to initiator.
REQ-011 SHALL have T_CYC, T_STB  out  1 each  cycle and strobe to target.
REQ-012 SHALL have T_STALL  in  1  target stall.
REQ-013 SHALL have T_ACK, T_ERR, T_RTY  in  1 each  target response.
REQ-014 SHALL have T_DAT  in  DataWidth  and  T_TGD  in  TGDWidth  target response data and tag.
REQ-015 SHALL leave request payload (ADDR, DAT, SEL, WE, tags) outside this block, unregistered.

Function
REQ-016 SHALL implement states IDLE, ACTIVE, FLUSH.
REQ-017 SHALL go IDLE->ACTIVE on I_CYC=1; ACTIVE->IDLE on I_CYC=0 with Out=0; ACTIVE->FLUSH on I_CYC=0 with Out>0, loading Timer=FlushTimeout.
REQ-018 SHALL go FLUSH->IDLE when Out reaches 0 or Timer reaches 0; on timeout Out is forced to 0.
REQ-019 SHALL drive T_CYC = I_CYC in IDLE/ACTIVE and T_CYC=1 in FLUSH.
REQ-020 SHALL drive T_STB = I_CYC & I_STB & (Out<MaxOutstanding) in ACTIVE, else 0.
REQ-021 SHALL drive I_STALL = T_STALL | (Out=MaxOutstanding) | (state=FLUSH).
REQ-022 SHALL count Accept = T_STB & !T_STALL; Response = T_CYC & (T_ACK|T_ERR|T_RTY) & Out>0.
REQ-023 SHALL update Out: +1 on Accept only, -1 on Response only, unchanged when both.
REQ-024 SHALL drop responses with Out=0 (spurious); no I_ACK/I_ERR/I_RTY is produced.
REQ-025 SHALL forward a counted response in ACTIVE as a single-cycle pulse of exactly one of I_ERR > I_RTY > I_ACK (priority when several asserted).
REQ-026 SHALL latch I_DAT/I_TGD from T_DAT/T_TGD on every forwarded response and hold otherwise.
REQ-027 SHALL discard responses counted in FLUSH (decrement Out, no initiator pulse).
REQ-028 SHALL ignore I_CYC re-assertion during FLUSH; IDLE->ACTIVE is taken the cycle after returning to IDLE if I_CYC=1.
REQ-029 SHALL decrement Timer by 1 per cycle in FLUSH, saturating at 0.

Reset
REQ-030 SHALL, on RST_n=0, immediately set state=IDLE, Out=0, Timer=0, I_ACK=I_ERR=I_RTY=0, I_DAT=0, I_TGD=0, T_CYC=T_STB=0, I_STALL=1.
REQ-031 SHALL abandon any outstanding requests on reset mid-transaction; no responses forwarded for them.

Configuration
REQ-032 SHALL honour macro WB_RSPTRACK_BYPASS_EN: defined -> response forwarding combinational (0-cycle latency, I_DAT/I_TGD = T_DAT/T_TGD on the response cycle); undefined -> registered, response pulses one cycle after T_ACK/T_ERR/T_RTY.

Verification (MaxOutstanding=4, FlushTimeout=16, macro undefined unless stated)
REQ-033 SHALL cover: 4 back-to-back strobes, T_STALL=0, no responses -> Out=4, I_STALL=1 on 5th cycle, T_STB=0.
REQ-034 SHALL cover: Out=2, same-cycle Accept and T_ACK with T_DAT=0xA5 -> Out stays 2, I_ACK=1 and I_DAT=0xA5 next cycle.
REQ-035 SHALL cover: T_ERR=1 and T_ACK=1 same cycle -> only I_ERR=1, one cycle.
REQ-036 SHALL cover: I_CYC drops with Out=3, target answers 3 within 5 cycles -> no initiator pulses, IDLE after third, I_STALL=0.
REQ-037 SHALL cover: I_CYC drops with Out=2, no responses -> FLUSH for 16 cycles, then IDLE with Out=0.
REQ-038 SHALL cover: WB_RSPTRACK_BYPASS_EN defined, T_ACK with T_DAT=0x3C -> I_ACK=1, I_DAT=0x3C same cycle.
